// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register: stage state encoding
// and the occupancy type, plus a helper mapping state to held-beat count.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  typedef logic [1:0] pipe_occ_t;

  function automatic pipe_occ_t occ_of(input pipe_state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Load-enabled WIDTH-wide data register with synchronous clear, used for the
// main entry and the optional skid entry of pipe_stage_reg.
module pipe_skid_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!resetn || i_clear)
      r_data <= '0;
    else if (i_load)
      r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and synchronous
// flush. Define PIPE_STAGE_SKID_EN to add the second (skid) entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter bit FLUSH_KEEPS_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  pipe_state_e      r_state;
  pipe_state_e      w_nextState;
  logic             w_inFire;
  logic             w_outFire;
  logic             w_mainLoad;
  logic             w_clearMain;
  logic [WIDTH-1:0] w_mainIn;
  logic [WIDTH-1:0] w_mainData;
`ifdef PIPE_STAGE_SKID_EN
  logic             w_skidLoad;
  logic             w_mainFromSkid;
  logic             r_inReady;
  logic [WIDTH-1:0] w_skidData;
`endif

  assign w_inFire    = in_valid & in_ready;
  assign w_outFire   = out_valid & out_ready;
  assign out_valid   = (r_state != EMPTY);
  assign occupancy   = occ_of(r_state);
  assign w_clearMain = flush & ~FLUSH_KEEPS_DATA;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= EMPTY;
    else
      r_state <= w_nextState;
  end

  // Flush overrides every handshake; no entry loads in a flush cycle.
  always_comb begin
    w_nextState = r_state;
    w_mainLoad  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_skidLoad     = 1'b0;
    w_mainFromSkid = 1'b0;
`endif
    if (flush) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            w_nextState = ONE;
            w_mainLoad  = 1'b1;
          end
        end
        ONE: begin
          if (w_inFire && w_outFire)
            w_mainLoad = 1'b1;
          else if (w_outFire)
            w_nextState = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          else if (w_inFire) begin
            w_nextState = TWO;
            w_skidLoad  = 1'b1;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          if (w_outFire) begin
            w_nextState    = ONE;
            w_mainLoad     = 1'b1;
            w_mainFromSkid = 1'b1;
          end
        end
`endif
        default: w_nextState = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign w_mainIn = w_mainFromSkid ? w_skidData : in_data;

  pipe_skid_entry #(.WIDTH(WIDTH)) u_skidEntry (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (flush),
    .i_load  (w_skidLoad),
    .i_data  (in_data),
    .o_data  (w_skidData)
  );

  // Registered ready breaks the out_ready -> in_ready path; gated low in reset.
  always_ff @(posedge clk) begin
    if (!resetn)
      r_inReady <= 1'b1;
    else
      r_inReady <= (w_nextState != TWO);
  end

  assign in_ready = r_inReady & resetn;
`else
  assign w_mainIn = in_data;
  assign in_ready = resetn & (~out_valid | out_ready);
`endif

  pipe_skid_entry #(.WIDTH(WIDTH)) u_mainEntry (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (w_clearMain),
    .i_load  (w_mainLoad),
    .i_data  (w_mainIn),
    .o_data  (w_mainData)
  );

  assign out_data = (out_valid || FLUSH_KEEPS_DATA) ? w_mainData : '0;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register with a valid/ready handshake, synchronous flush (bubble insertion) and an optional two-entry skid buffer. It replaces the fixed per-stage F/D/E/M/W registers of the 5-stage core with one reusable block. Upstream stage logic drives `in_*`, and the next stage consumes `out_*`. It adds back-pressure, stall and flush handling that the old bubble-only stage registers lacked.

## Interface
- `WIDTH`, default 32: payload width in bits. The stage packs pc, icode, acode, dst, val and write_enable into one vector.
- `FLUSH_KEEPS_DATA`, default 0: when 1, `out_data` holds its last value while invalid. When 0, `out_data` is forced to 0 while `out_valid`=0.

- `clk`  in  1  clock, all state updates on the rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  stage holds a valid beat
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDTH  payload to downstream
- `flush`  in  1  discard all held beats (bubble)
- `occupancy`  out  2  number of held beats, 0..2

## Operation
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- Beats leave in strict arrival order. No beat is duplicated or dropped, except under flush.
- State machine with skid enabled:
  - EMPTY (occ 0). Accept in -> ONE.
  - ONE (occ 1, main entry). Simultaneous in and out -> ONE, main entry loads `in_data`. Out only -> EMPTY. In only -> TWO, beat goes to the skid entry.
  - TWO (occ 2). `in_ready`=0. Out -> ONE, main entry loads the skid entry.
- Without skid, only EMPTY and ONE exist. `occupancy` is 0 or 1.
- Flush:
  - Next state is EMPTY regardless of the handshakes.
  - An in-transfer in the same cycle is discarded.
  - An out-transfer in the same cycle still completes.
  - Flush has priority over every other transition.
- `out_data`:
  - When `out_valid`=1, it is the main entry.
  - When `out_valid`=0, it is 0, or the held value if `FLUSH_KEEPS_DATA`=1.
- Holding `out_ready`=0 is the stall mechanism. `out_data` must remain stable while `out_valid & ~out_ready`.

## Timing
- Reset, checked at a rising edge with `resetn`=0:
  - state EMPTY, `out_valid`=0, `out_data`=0, `occupancy`=0
  - `in_ready`=0 while `resetn`=0, and 1 in the first cycle after.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one beat per cycle with continuous `out_ready`.
- Flush asserted during cycle N: `out_valid`=0 after edge N.
- Reset during operation behaves like flush and additionally zeroes the data.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid entry present.
  - `in_ready` is a register, driven from state only (`in_ready` = state != TWO). There is no combinational path from `out_ready` to `in_ready`.
- Not defined:
  - Single entry. `in_ready` = `~out_valid | out_ready`, which is combinational, with zero-bubble pass-through.
  - The TWO state is removed.

## Structure
- Shared package `pipe_pkg`: state enum `pipe_state_e` {EMPTY, ONE, TWO} and the `pipe_occ_t` 2-bit typedef.
- One sub-module, `pipe_skid_entry`: a WIDTH-wide load-enabled data register with clear. It is instantiated for the main entry and, under `PIPE_STAGE_SKID_EN`, for the skid entry.
- Stage payload structs are packed per stage by the instantiating module, not in this block.

## Test plan
- Reset, then stream 0x11, 0x22, 0x33 with `out_ready`=1 -> out shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle after input; `occupancy` stays 1.
- Skid on: send 0xA, 0xB back-to-back, `out_ready`=0 -> `occupancy`=2, `in_ready`=0, `out_data`=0xA held stable. Release `out_ready` -> 0xA then 0xB, no loss.
- Skid off, same stimulus -> `in_ready`=0 after 0xA is held. 0xB is not accepted until 0xA drains. Order is preserved.
- Flush in TWO together with `in_valid` and 0xC -> next cycle `out_valid`=0, `out_data`=0, `occupancy`=0, 0xC is never output.
- Flush and out-transfer in the same cycle with 0xD -> 0xD is consumed once, then the stage is EMPTY.
- Reset pulse mid-stream in ONE -> all outputs return to their reset values. Streaming resumes cleanly the cycle after reset with `in_ready`=1.
